// File: rtl/and_share_arb.sv
// Round-robin arbiter feeding one shared AND cell, with a per-requester tie mode on operand B.
// Latency: 1 cycle. The grant is combinational and the result is registered on the next edge.
// Backpressure: a held result (res_valid & !res_ready) blocks all grants until it is accepted.
module and_share_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   gnt,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_idx,
  input  logic [1:0]     cfg_tie,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [IDW-1:0] res_id,
  output logic           res_y
);

  localparam logic [1:0] TIE_B   = 2'b00;
  localparam logic [1:0] TIE_GND = 2'b01;
  localparam logic [1:0] TIE_VCC = 2'b10;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_y_q, res_y_d;
  logic [1:0]     tie_q [N];
  logic [1:0]     tie_d [N];

  logic           free;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic           b_eff;
  logic [1:0]     tie_sel;

  // Scan requests starting at rr_ptr and grant the first one, if the result slot is free.
  always_comb begin
    int idx;
    free    = !res_valid_q || res_ready;
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!rst && free) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld && req[idx]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = IDW'(idx);
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  // Resolve operand B through the granted requester's tie mode; don't-care resolves to 0.
  always_comb begin
    tie_sel = tie_q[gnt_idx];
    case (tie_sel)
      TIE_B:   b_eff = b[gnt_idx];
      TIE_GND: b_eff = 1'b0;
      TIE_VCC: b_eff = 1'b1;
      default: b_eff = 1'b0;
    endcase
  end

  // Next state for the result slot, the round-robin pointer and the tie registers.
  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_y_d     = res_y_q;
    rr_ptr_d    = rr_ptr_q;
    tie_d       = tie_q;
    if (gnt_vld) begin
      res_valid_d = 1'b1;
      res_id_d    = gnt_idx;
      res_y_d     = a[gnt_idx] & b_eff;
      rr_ptr_d    = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDW'(1);
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    // The grant above reads tie_q, so a write to the granted index only affects later grants.
    if (cfg_we && (int'(cfg_idx) < N)) begin
      tie_d[cfg_idx] = cfg_tie;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= 1'b0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < N; i++) tie_q[i] <= TIE_B;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_y_q     <= res_y_d;
      rr_ptr_q    <= rr_ptr_d;
      tie_q       <= tie_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_y     = res_y_q;

endmodule

// File: tb/tb_and_share_arb.sv
// Directed table-driven bench for and_share_arb plus hand-written reset sequences.
module tb_and_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, a, b, gnt;
  logic       cfg_we;
  logic [1:0] cfg_idx, cfg_tie;
  logic       res_valid, res_ready, res_y;
  logic [1:0] res_id;

  int checks   = 0;
  int failures = 0;

  and_share_arb #(.N(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tie(cfg_tie),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_y(res_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic       rdy;
    logic       we;
    logic [1:0] idx;
    logic [1:0] tie;
    logic [3:0] exp_gnt;
    logic       exp_vld;
    logic [1:0] exp_id;
    logic       exp_y;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // req, a, b, rdy, we, idx, tie | gnt, vld, id, y (result after the edge)
    vecs[0]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 4'b1010, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[2]  = '{4'b1111, 4'b1010, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[3]  = '{4'b1111, 4'b1010, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[4]  = '{4'b1111, 4'b1010, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1010, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[6]  = '{4'b1111, 4'b1010, 4'b1111, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 2'b01, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 2'b10, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'b11, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{4'b1110, 4'b1110, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[11] = '{4'b1110, 4'b1110, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[12] = '{4'b1110, 4'b1110, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[13] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1, 2'd2, 1'b1};
    vecs[14] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1, 2'd2, 1'b1};
    vecs[15] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1, 2'd2, 1'b1};
    vecs[16] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[17] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b01, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[18] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[20] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 2'b00, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[21] = '{4'b0011, 4'b0011, 4'b0011, 1'b0, 1'b0, 2'd0, 2'b00, 4'b0000, 1'b1, 2'd0, 1'b1};

    // Reset with all requests asserted: no grant, result slot cleared.
    rst = 1'b1; req = 4'b1111; a = 4'b1111; b = 4'b1111;
    cfg_we = 1'b0; cfg_idx = 2'd0; cfg_tie = 2'b00; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_vld", 32'(res_valid), 32'h0);
    chk("reset_id",  32'(res_id), 32'h0);
    chk("reset_y",   32'(res_y), 32'h0);
    rst = 1'b0; req = 4'b0000;

    for (int i = 0; i < NV; i++) begin
      req = vecs[i].req; a = vecs[i].a; b = vecs[i].b; res_ready = vecs[i].rdy;
      cfg_we = vecs[i].we; cfg_idx = vecs[i].idx; cfg_tie = vecs[i].tie;
      #3;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), 32'(res_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("v%0d_id", i),  32'(res_id), 32'(vecs[i].exp_id));
      chk($sformatf("v%0d_y", i),   32'(res_y), 32'(vecs[i].exp_y));
    end
    cfg_we = 1'b0;

    // Grant requester 1 so that rr_ptr becomes 2 with a result pending.
    req = 4'b0010; a = 4'b0000; b = 4'b0000; res_ready = 1'b1;
    #3;
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    @(posedge clk);
    #1;
    chk("pre_rst_vld", 32'(res_valid), 32'h1);
    chk("pre_rst_id",  32'(res_id), 32'h1);

    // Mid-cycle reset drops the pending result immediately.
    req = 4'b1111; a = 4'b1111; b = 4'b1111;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(res_valid), 32'h0);
    chk("mid_rst_id",  32'(res_id), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("post_rst_gnt0", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_id0", 32'(res_id), 32'h0);
    chk("post_rst_y0",  32'(res_y), 32'h1);
    #2;
    chk("post_rst_gnt1", 32'(gnt), 32'h2);
    @(posedge clk);
    #1;
    chk("post_rst_id1", 32'(res_id), 32'h1);
    // Requester 1 had GND tie before reset; after reset it is back to plain B.
    chk("post_rst_y1",  32'(res_y), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
